// File: rtl/aes_word_seq.sv
// Word-serial front end for a 128-bit AES core: packs 32-bit key/text words into
// 128-bit operands, launches the core, and streams the ciphertext back out as words.
module aes_word_seq #(
    parameter int unsigned TIMEOUT = 31,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_key,

    output logic              ld,
    output logic [127:0]      key,
    output logic [127:0]      text_in,
    input  logic              done,
    input  logic [127:0]      text_out,

    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_data,

    output logic              err_nokey,
    output logic              err_tmo,
    output logic [CNT_W-1:0]  blk_cnt
);

    localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        StFill   = 2'd0,
        StLaunch = 2'd1,
        StBusy   = 2'd2,
        StDrain  = 2'd3
    } state_t;

    state_t            state_q;
    logic [1:0]        key_cnt_q;
    logic [1:0]        txt_cnt_q;
    logic [1:0]        out_cnt_q;
    logic              key_vld_q;
    logic              ld_q;
    logic              err_nokey_q;
    logic              err_tmo_q;
    logic [WD_W-1:0]   wdog_q;
    logic [CNT_W-1:0]  blk_cnt_q;
    logic [127:0]      key_q;
    logic [127:0]      text_q;
    logic [127:0]      result_q;

    logic              s_hs;
    logic              key_hs;
    logic              txt_hs;
    logic              key_ready;
    logic              capture;

    assign s_ready   = (state_q == StFill);
    assign m_valid   = (state_q == StDrain);
    assign s_hs      = s_valid && s_ready;
    assign key_hs    = s_hs && s_key;
    assign txt_hs    = s_hs && !s_key;
    // A key is usable only when complete and no replacement key is half-loaded.
    assign key_ready = key_vld_q && (key_cnt_q == 2'd0);
    assign capture   = (state_q == StBusy) && done;

    assign ld        = ld_q;
    assign err_nokey = err_nokey_q;
    assign err_tmo   = err_tmo_q;
    assign blk_cnt   = blk_cnt_q;
    assign key       = key_q;
    assign text_in   = text_q;
    // Word index 0 selects bits [127:96]; ~cnt turns the index into an MSB-first lane.
    assign m_data    = result_q[{~out_cnt_q, 5'b0} +: 32];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StFill;
            key_cnt_q   <= '0;
            txt_cnt_q   <= '0;
            out_cnt_q   <= '0;
            key_vld_q   <= 1'b0;
            ld_q        <= 1'b0;
            err_nokey_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            wdog_q      <= '0;
            blk_cnt_q   <= '0;
        end else begin
            ld_q        <= 1'b0;
            err_nokey_q <= 1'b0;
            err_tmo_q   <= 1'b0;
            unique case (state_q)
                StFill: begin
                    if (key_hs) begin
                        key_cnt_q <= key_cnt_q + 2'd1;
                        if (key_cnt_q == 2'd3) begin
                            key_vld_q <= 1'b1;
                        end else if (key_cnt_q == 2'd0) begin
                            key_vld_q <= 1'b0;
                        end
                    end
                    if (txt_hs) begin
                        if (txt_cnt_q == 2'd3) begin
                            txt_cnt_q <= '0;
                            if (key_ready) begin
                                state_q <= StLaunch;
                                ld_q    <= 1'b1;
                            end else begin
                                err_nokey_q <= 1'b1;
                            end
                        end else begin
                            txt_cnt_q <= txt_cnt_q + 2'd1;
                        end
                    end
                end
                StLaunch: begin
                    state_q <= StBusy;
                    wdog_q  <= '0;
                end
                StBusy: begin
                    if (done) begin
                        state_q <= StDrain;
                        wdog_q  <= '0;
                    end else if (wdog_q == WD_LAST) begin
                        state_q   <= StFill;
                        err_tmo_q <= 1'b1;
                        txt_cnt_q <= '0;
                        wdog_q    <= '0;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                StDrain: begin
                    if (m_ready) begin
                        out_cnt_q <= out_cnt_q + 2'd1;
                        if (out_cnt_q == 2'd3) begin
                            state_q   <= StFill;
                            blk_cnt_q <= blk_cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= StFill;
            endcase
        end
    end

    // Operand assembly; handshakes only occur in StFill, so operands hold while the core runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q  <= '0;
            text_q <= '0;
        end else begin
            if (key_hs) begin
                key_q[{~key_cnt_q, 5'b0} +: 32] <= s_data;
            end
            if (txt_hs) begin
                text_q[{~txt_cnt_q, 5'b0} +: 32] <= s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else if (capture) begin
            result_q <= text_out;
        end
    end

    a_ld_single: assert property (@(posedge clk) disable iff (!rst) ld |=> !ld);

    a_ld_needs_key: assert property (@(posedge clk) disable iff (!rst) ld |-> key_vld_q);

    a_m_hold: assert property (@(posedge clk) disable iff (!rst)
        (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));

    a_operands_hold: assert property (@(posedge clk) disable iff (!rst)
        (state_q != StFill) |=> ($stable(key) && $stable(text_in)));

endmodule
